// File: rtl/updown_counter_p.sv
// rtl/updown_counter_p.sv - parametrised up/down counter with load, wrap/saturate, sticky flags
// Optional q_par (even parity of q) enabled by defining COUNTER_PARITY_EN.
module updown_counter_p #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
`ifdef COUNTER_PARITY_EN
    ,
    output logic             q_par
`endif
);

    if (WIDTH < 2 || STEP == 0 || STEP > MAX_VAL || MAX_VAL > 2**WIDTH-1) begin : g_param_err
        $error("updown_counter_p: illegal WIDTH/STEP/MAX_VAL combination");
    end

    // One extra bit so q+STEP and q+MOD-STEP never truncate before the limit compare.
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_W  = MAX_W + (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   dn_wrap;
    logic [WIDTH:0]   ld_ext;
    logic [WIDTH-1:0] q_nxt;
    logic             set_ovf;
    logic             set_unf;

    always_comb begin
        q_ext   = {1'b0, q};
        ld_ext  = {1'b0, data_in};
        up_sum  = q_ext + STEP_W;
        up_wrap = up_sum - MOD_W;
        dn_diff = q_ext - STEP_W;
        dn_wrap = q_ext + MOD_W - STEP_W;
        q_nxt   = q;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (ld) begin
            q_nxt = (ld_ext > MAX_W) ? MAX_Q : data_in;
        end else if (inc && !dec) begin
            if (up_sum <= MAX_W) begin
                q_nxt = up_sum[WIDTH-1:0];
            end else begin
                set_ovf = 1'b1;
                q_nxt   = (SATURATE != 0) ? MAX_Q : up_wrap[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (q_ext >= STEP_W) begin
                q_nxt = dn_diff[WIDTH-1:0];
            end else begin
                set_unf = 1'b1;
                q_nxt   = (SATURATE != 0) ? '0 : dn_wrap[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            q   <= q_nxt;
            // A flag being set on this edge beats a simultaneous clear.
            ovf <= set_ovf | (ovf & ~clr_flags);
            unf <= set_unf | (unf & ~clr_flags);
        end
    end

`ifdef COUNTER_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_par <= 1'b0;
        end else begin
            q_par <= ^q_nxt;
        end
    end
`endif

    assign at_max = (q == MAX_Q);
    assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_p.sv
// tb/tb_updown_counter_p.sv - randomized bench for updown_counter_p against a behavioural model
module tb_updown_counter_p;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       ld;
    logic       inc;
    logic       dec;
    logic       clr_flags;

    logic [7:0] q_o [3];
    logic       at_max_o [3];
    logic       at_min_o [3];
    logic       ovf_o [3];
    logic       unf_o [3];
`ifdef COUNTER_PARITY_EN
    logic       q_par_o [3];
`endif

    int maxv  [3] = '{255, 255, 9};
    int stepv [3] = '{1, 3, 4};
    int satv  [3] = '{0, 1, 0};
    int mq [3];
    int mo [3];
    int mu [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    updown_counter_p #(.WIDTH(8), .STEP(1), .MAX_VAL(255), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .q(q_o[0]), .at_max(at_max_o[0]), .at_min(at_min_o[0]),
        .ovf(ovf_o[0]), .unf(unf_o[0])
`ifdef COUNTER_PARITY_EN
        , .q_par(q_par_o[0])
`endif
    );

    updown_counter_p #(.WIDTH(8), .STEP(3), .MAX_VAL(255), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .q(q_o[1]), .at_max(at_max_o[1]), .at_min(at_min_o[1]),
        .ovf(ovf_o[1]), .unf(unf_o[1])
`ifdef COUNTER_PARITY_EN
        , .q_par(q_par_o[1])
`endif
    );

    updown_counter_p #(.WIDTH(8), .STEP(4), .MAX_VAL(9), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .clr_flags(clr_flags), .q(q_o[2]), .at_max(at_max_o[2]), .at_min(at_min_o[2]),
        .ovf(ovf_o[2]), .unf(unf_o[2])
`ifdef COUNTER_PARITY_EN
        , .q_par(q_par_o[2])
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Apply one edge of stimulus, advance the model, compare every output of every instance.
    task automatic cyc(input logic r, input logic l, input logic i, input logic d,
                       input logic c, input logic [7:0] din);
        int so;
        int su;
        rst = r; ld = l; inc = i; dec = d; clr_flags = c; data_in = din;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            so = 0;
            su = 0;
            if (!r) begin
                mq[k] = 0; mo[k] = 0; mu[k] = 0;
            end else begin
                if (l) begin
                    mq[k] = (int'(din) > maxv[k]) ? maxv[k] : int'(din);
                end else if (i && !d) begin
                    if (mq[k] + stepv[k] <= maxv[k]) mq[k] = mq[k] + stepv[k];
                    else begin
                        so = 1;
                        mq[k] = satv[k] ? maxv[k] : mq[k] + stepv[k] - (maxv[k] + 1);
                    end
                end else if (d && !i) begin
                    if (mq[k] >= stepv[k]) mq[k] = mq[k] - stepv[k];
                    else begin
                        su = 1;
                        mq[k] = satv[k] ? 0 : mq[k] + (maxv[k] + 1) - stepv[k];
                    end
                end
                mo[k] = so ? 1 : (c ? 0 : mo[k]);
                mu[k] = su ? 1 : (c ? 0 : mu[k]);
            end
            check($sformatf("q%0d", k), int'(q_o[k]), mq[k]);
            check($sformatf("at_max%0d", k), int'(at_max_o[k]), int'(mq[k] == maxv[k]));
            check($sformatf("at_min%0d", k), int'(at_min_o[k]), int'(mq[k] == 0));
            check($sformatf("ovf%0d", k), int'(ovf_o[k]), mo[k]);
            check($sformatf("unf%0d", k), int'(unf_o[k]), mu[k]);
`ifdef COUNTER_PARITY_EN
            check($sformatf("q_par%0d", k), int'(q_par_o[k]), $countones(mq[k]) % 2);
`endif
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0; mo[k] = 0; mu[k] = 0;
        end
        cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'hAB);

        // reset with q=0x5A and ovf set
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 0, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 8'h5A);
        check("t1_pre_q", int'(q_o[0]), 'h5A);
        check("t1_pre_ovf", int'(ovf_o[0]), 1);
        cyc(0, 1, 1, 0, 0, 8'h33);
        check("t1_q", int'(q_o[0]), 0);
        check("t1_ovf", int'(ovf_o[0]), 0);
        check("t1_at_min", int'(at_min_o[0]), 1);
        check("t1_at_max", int'(at_max_o[0]), 0);

        // wrap at top, step 1
        cyc(1, 1, 0, 0, 0, 8'hFE);
        cyc(1, 0, 1, 0, 0, 8'h00);
        check("t2_q_ff", int'(q_o[0]), 'hFF);
        check("t2_at_max", int'(at_max_o[0]), 1);
        check("t2_ovf_clear", int'(ovf_o[0]), 0);
        cyc(1, 0, 1, 0, 0, 8'h00);
        check("t2_q_wrap", int'(q_o[0]), 0);
        check("t2_ovf_set", int'(ovf_o[0]), 1);

        // saturate at bottom, step 3
        cyc(1, 1, 0, 0, 0, 8'h02);
        cyc(1, 0, 0, 1, 0, 8'h00);
        check("t3_q", int'(q_o[1]), 0);
        check("t3_unf", int'(unf_o[1]), 1);
        cyc(1, 0, 0, 1, 0, 8'h00);
        check("t3_q_again", int'(q_o[1]), 0);
        check("t3_unf_again", int'(unf_o[1]), 1);

        // MAX_VAL=9, step 4, wrap
        cyc(0, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 8'd8);
        cyc(1, 0, 1, 0, 0, 8'h00);
        check("t4_q_up", int'(q_o[2]), 2);
        check("t4_ovf", int'(ovf_o[2]), 1);
        cyc(1, 0, 0, 1, 0, 8'h00);
        check("t4_q_dn", int'(q_o[2]), 8);
        check("t4_unf", int'(unf_o[2]), 1);
        cyc(1, 1, 0, 0, 0, 8'd15);
        check("t4_q_clamp", int'(q_o[2]), 9);

        // simultaneous controls and set-beats-clear
        cyc(1, 1, 0, 0, 0, 8'd5);
        cyc(1, 0, 1, 1, 0, 8'h00);
        check("t5_hold_q", int'(q_o[0]), 5);
        check("t5_hold_ovf", int'(ovf_o[0]), 0);
        cyc(1, 1, 1, 0, 0, 8'd7);
        check("t5_ld_wins", int'(q_o[0]), 7);
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 0, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 8'hFF);
        cyc(1, 0, 1, 0, 1, 8'h00);
        check("t5_set_wins", int'(ovf_o[0]), 1);
        cyc(1, 0, 0, 0, 1, 8'h00);
        check("t5_clr", int'(ovf_o[0]), 0);

`ifdef COUNTER_PARITY_EN
        cyc(1, 1, 0, 0, 0, 8'h07);
        check("t6_par7", int'(q_par_o[0]), 1);
        cyc(1, 0, 1, 0, 0, 8'h00);
        check("t6_par8", int'(q_par_o[0]), 1);
        cyc(1, 0, 1, 0, 0, 8'h00);
        check("t6_par9", int'(q_par_o[0]), 0);
`endif

        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0),
                1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
